// File: rtl/seven_segment_arbiter.sv
// Round-robin time-sharing of one 32-bit seven-segment display value among NUM_REQ requesters.
// Optional build macro: SEVEN_SEGMENT_ARBITER_PREEMPT_EN (requester 0 preempts and holds while requesting).
module seven_segment_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [32*NUM_REQ-1:0]  val_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic [2:0]             owner_out,
    output logic                   active_out,
    output logic [31:0]            val_out
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [2:0]    ptr, nxt_owner;
    logic          win_found;
    logic [2:0]    win_idx;
    logic          owner_req;
    logic [31:0]   nxt_val;
    int            best;

    // Winner is the requester closest after ptr, so the last owner itself is searched last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        best      = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_in[i] && (((i + 2*NUM_REQ - 1 - int'(ptr)) % NUM_REQ) < best)) begin
                best      = (i + 2*NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    assign owner_req = |(req_in & grant_out);

    always_comb begin
        nxt_state = state;
        nxt_owner = owner_out;
        nxt_cnt   = cnt;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
                if (req_in[0]) begin
                    nxt_state = SHOW;
                    nxt_owner = '0;
                end else
`endif
                if (win_found) begin
                    nxt_state = SHOW;
                    nxt_owner = win_idx;
                end
            end
            SHOW: begin
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
                if (req_in[0] && owner_out != 3'd0) begin
                    nxt_owner = '0;
                    nxt_cnt   = '0;
                end else if (req_in[0]) begin
                    nxt_cnt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                end else
`endif
                if (!owner_req) begin
                    nxt_cnt = '0;
                    if (win_found) nxt_owner = win_idx;
                    else           nxt_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    nxt_cnt   = '0;
                    nxt_owner = win_idx;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (nxt_state == SHOW && i == int'(nxt_owner)) nxt_val = val_in[32*i +: 32];
        end
    end

    // All visible outputs are registered from the next-state owner so they move on one edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= 3'(NUM_REQ - 1);
            grant_out  <= '0;
            owner_out  <= '0;
            active_out <= 1'b0;
            val_out    <= '0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            if (nxt_state == SHOW) ptr <= nxt_owner;
            grant_out  <= (nxt_state == SHOW) ? (NUM_REQ'(1) << nxt_owner) : '0;
            owner_out  <= (nxt_state == SHOW) ? nxt_owner : '0;
            active_out <= (nxt_state == SHOW);
            val_out    <= nxt_val;
        end
    end
endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed and randomized checks of seven_segment_arbiter (NUM_REQ=4, DWELL_CYCLES=8) against a
// cycles-held ownership model.
module tb_seven_segment_arbiter;
    localparam int N     = 4;
    localparam int DWELL = 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [N-1:0]  req_in = '0;
    logic [32*N-1:0] val_in = '0;
    logic [N-1:0]  grant_out;
    logic [2:0]    owner_out;
    logic          active_out;
    logic [31:0]   val_out;

    int tests = 0;
    int fails = 0;

    bit m_active;
    int m_owner;
    int m_held;
    int m_last;
    logic [31:0] m_val;

    seven_segment_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DWELL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .val_in(val_in),
        .grant_out(grant_out), .owner_out(owner_out), .active_out(active_out), .val_out(val_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic bit rq(input logic [N-1:0] r, input int i);
        return ((r >> i) & N'(1)) != '0;
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_held   = 0;
        m_last   = N - 1;
        m_val    = '0;
    endfunction

    // Ownership advances on each clock edge from the inputs present before it.
    function automatic void model_step(input logic [N-1:0] r, input logic [32*N-1:0] v);
        int cand = -1;
        for (int k = 1; k <= N; k++)
            if (cand < 0 && rq(r, (m_last + k) % N)) cand = (m_last + k) % N;
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
        if (rq(r, 0)) begin
            if (m_active && m_owner == 0) m_held = 1;
            else begin m_active = 1'b1; m_owner = 0; m_held = 1; m_last = 0; end
        end else
`endif
        if (!m_active) begin
            if (cand >= 0) begin m_active = 1'b1; m_owner = cand; m_held = 1; m_last = cand; end
        end else if (!rq(r, m_owner)) begin
            if (cand >= 0) begin m_owner = cand; m_held = 1; m_last = cand; end
            else m_active = 1'b0;
        end else if (m_held == DWELL) begin
            m_owner = cand; m_held = 1; m_last = cand;
        end else begin
            m_held++;
        end
        m_val = m_active ? 32'(v >> (32 * m_owner)) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"},  32'(grant_out),  m_active ? 32'(1 << m_owner) : 32'd0);
        check({tag, ".owner"},  32'(owner_out),  m_active ? 32'(m_owner) : 32'd0);
        check({tag, ".active"}, 32'(active_out), 32'(m_active));
        check({tag, ".val"},    val_out,         m_val);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string tag, input logic [N-1:0] r, input logic [32*N-1:0] v);
        req_in = r;
        val_in = v;
        model_step(r, v);
        @(posedge clk_in);
        #1;
        check_all(tag);
        @(negedge clk_in);
    endtask

    task automatic do_reset(input string tag);
        rst_in = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk_in);
        req_in = '0;
        rst_in = 1'b1;
    endtask

    function automatic logic [32*N-1:0] rand_vals();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [32*N-1:0] v;
        logic [N-1:0]    r;
        model_reset();
        @(negedge clk_in);
        do_reset("reset");
        for (int i = 0; i < 3; i++) step("idle", 4'b0000, rand_vals());

        v = '0;
        v[64 +: 32] = 32'h0000_BEEF;
        step("single_first", 4'b0100, v);
        check("single_owner_is_2", 32'(owner_out), 32'd2);
        check("single_val_beef", val_out, 32'h0000_BEEF);
        for (int i = 0; i < 2*DWELL + 3; i++) step("single_hold", 4'b0100, v);

        do_reset("reset_mid_show");
        for (int i = 0; i < 5*DWELL + 2; i++) step("rotation_live", 4'b1111, rand_vals());

        do_reset("reset_b");
        for (int i = 0; i < 4; i++) step("early_setup", 4'b0010, rand_vals());
        step("early_to_idle", 4'b0000, rand_vals());
        check("early_idle_active", 32'(active_out), 32'd0);
        for (int i = 0; i < 4; i++) step("early_setup2", 4'b0010, rand_vals());
        step("early_handoff", 4'b1000, rand_vals());
        check("early_handoff_owner", 32'(owner_out), 32'd3);

        do_reset("reset_c");
        for (int i = 0; i < DWELL; i++) step("expire_setup", 4'b0010, rand_vals());
        step("expire_and_release", 4'b0001, rand_vals());
        check("expire_release_owner", 32'(owner_out), 32'd0);

        do_reset("reset_d");
        for (int i = 0; i < 3; i++) step("preempt_setup", 4'b0100, rand_vals());
        for (int i = 0; i < 2*DWELL + 2; i++) step("preempt_req0", 4'b0101, rand_vals());

        do_reset("reset_e");
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) do_reset("rand_reset");
            else step("random", r, rand_vals());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
